// File: rtl/serial_add8.sv
// Bit-serial unsigned adder: sum/cout = a + b + cin, one bit per cycle, LSB first.
// Latency: start accepted at cycle 0 -> busy in cycles 1..WIDTH, done pulse and result in cycle WIDTH+1.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy or done.
module serial_add8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter is one bit wider than needed to index WIDTH bits so it never wraps before the terminal count.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] psum_next;
    logic             last_bit;

    // One full-adder slice on the current LSBs; the new sum bit enters the partial sum at the MSB end.
    always_comb begin
        sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        psum_next  = (psum >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
        last_bit   = (bit_cnt == CW'(WIDTH - 1));
    end

    // Control FSM plus datapath registers; busy/done/sum/cout are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            psum    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Snapshot operands so later input changes cannot disturb this operation.
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= cin;
                        psum    <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= carry_next;
                    psum    <= psum_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        // Publish the complete result only here so sum/cout never show partial values.
                        sum   <= psum_next;
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add8.sv
// Self-checking bench for serial_add8: directed scenarios followed by randomized traffic.
// Latency: expectations derived from accept cycle + fixed WIDTH-cycle run, checked every cycle.
// Backpressure: start is driven freely; the model drops starts that arrive outside IDLE.
module tb_serial_add8;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: an operation is "when it was accepted" plus "what the arithmetic result is".
    int       n      = 0;
    bit       active = 0;
    int       acc    = 0;
    logic [8:0] pend = '0;
    logic [7:0] exp_sum  = '0;
    logic       exp_cout = 1'b0;

    serial_add8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check this cycle's outputs against the model, then advance one clock.
    task automatic run_cycle(input logic st, input logic [7:0] aa, input logic [7:0] bb,
                             input logic ci, input logic r);
        bit e_busy;
        bit e_done;
        start = st;
        a     = aa;
        b     = bb;
        cin   = ci;
        rst   = r;
        if (active && n == acc + W + 1) begin
            exp_sum  = pend[7:0];
            exp_cout = pend[8];
        end
        e_busy = active && (n > acc) && (n <= acc + W);
        e_done = active && (n == acc + W + 1);
        chk("busy", {8'h00, busy}, {8'h00, e_busy});
        chk("done", {8'h00, done}, {8'h00, e_done});
        chk("sum",  {1'b0, sum},   {1'b0, exp_sum});
        chk("cout", {8'h00, cout}, {8'h00, exp_cout});
        if (r) begin
            active   = 0;
            exp_sum  = '0;
            exp_cout = 1'b0;
        end else if (active) begin
            if (n == acc + W + 1) active = 0;
        end else if (st) begin
            active = 1;
            acc    = n;
            pend   = {1'b0, aa} + {1'b0, bb} + {8'h00, ci};
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, held for a couple of cycles, with start asserted to show reset wins.
        run_cycle(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // 0x3C + 0x25: busy cycles 1..8, done in cycle 9, sum 0x61.
        run_cycle(1'b1, 8'h3C, 8'h25, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) run_cycle(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        chk("r31_done", {8'h00, done}, 9'h001);
        chk("r31_sum",  {1'b0, sum},   9'h061);
        chk("r31_cout", {8'h00, cout}, 9'h000);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Carry-out boundaries: FF+01 and FF+FF+1.
        run_cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("ff01_sum",  {1'b0, sum},   9'h000);
        chk("ff01_cout", {8'h00, cout}, 9'h001);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_cycle(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("ffff1_sum",  {1'b0, sum},   9'h0FF);
        chk("ffff1_cout", {8'h00, cout}, 9'h001);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Starts during RUN (cycle 3) and DONE (cycle 9) are dropped.
        run_cycle(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) run_cycle(i == 3, 8'h01, 8'h01, 1'b0, 1'b0);
        chk("drop_sum", {1'b0, sum}, 9'h030);
        run_cycle(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk("drop_nodone", {8'h00, done}, 9'h000);
            run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Operands scrambled every RUN cycle after capturing 0x80 + 0x80.
        run_cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) run_cycle(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        chk("scr_sum",  {1'b0, sum},   9'h000);
        chk("scr_cout", {8'h00, cout}, 9'h001);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset in RUN cycle 4 aborts; next start 1+2+1 = 4.
        run_cycle(1'b1, 8'hC3, 8'h7E, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("abort_busy", {8'h00, busy}, 9'h000);
        chk("abort_sum",  {1'b0, sum},   9'h000);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_cycle(1'b1, 8'h01, 8'h02, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("post_rst_sum",  {1'b0, sum},   9'h004);
        chk("post_rst_cout", {8'h00, cout}, 9'h000);
        run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Start held high for 30 cycles: done in relative cycles 9, 19, 29.
        for (int i = 0; i < 30; i++) begin
            if (i == 9 || i == 19 || i == 29) begin
                chk("b2b_done", {8'h00, done}, 9'h001);
                chk("b2b_sum",  {1'b0, sum},   9'h080);
            end
            run_cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with sporadic resets and free-running operand noise.
        for (int i = 0; i < 600; i++) begin
            run_cycle(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 1'($urandom),
                      ($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
